// File: rtl/dbg_cmd_sysclk_decoder.sv
// rtl/dbg_cmd_sysclk_decoder.sv - system-clock side of the JTAG debug slave command decoder
//
// Synchronises the TCK-domain update-IR / update-DR levels into clk, captures
// the instruction and shift-register snapshot, and decodes each update-DR into
// a per-channel take_action / take_no_action strobe (or held level when
// ACK_MODE=1).
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   vs_uir, vs_udr    update-IR / update-DR levels from the TCK domain
//   ir_in             instruction, stable around vs_uir
//   sr                shift-register contents, stable around vs_udr
//   action_ack        per-channel accept from the debug unit (ACK_MODE=1)
//   overrun_clr       clears overrun and overrun_cnt
//   jdo               captured sr snapshot
//   take_action       per-channel action strobe/level
//   take_no_action    per-channel no-action strobe/level
//   cmd_pending       a command awaits ack (ACK_MODE=1)
//   overrun           sticky: blocked command or command on a disabled channel
//   overrun_cnt       saturating count of overrun events
module dbg_cmd_sysclk_decoder #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  localparam int NUM_CH     = 2**IR_W,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] CH_EN = '1,
  parameter int ACK_MODE    = 0,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [SR_W-1:0]   sr,
  input  logic [NUM_CH-1:0] action_ack,
  input  logic              overrun_clr,
  output logic [SR_W-1:0]   jdo,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic              cmd_pending,
  output logic              overrun,
  output logic [CNT_W-1:0]  overrun_cnt
);

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_dly;
  logic                   udr_dly;
  logic [IR_W-1:0]        ir_q;

  logic                   uir_rise;
  logic                   udr_rise;
  logic                   ack_hit;
  logic                   blocked;
  logic                   accept;
  logic                   ovr_evt;
  logic [NUM_CH-1:0]      ch_onehot;

  assign uir_rise  = uir_sync[SYNC_STAGES-1] & ~uir_dly;
  assign udr_rise  = udr_sync[SYNC_STAGES-1] & ~udr_dly;
  assign ch_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << ir_q;

  // Only the pending channel's ack counts; the held strobe marks that channel.
  assign ack_hit = (ACK_MODE != 0) && cmd_pending &&
                   (|(action_ack & (take_action | take_no_action)));
  assign blocked = (ACK_MODE != 0) && cmd_pending && !ack_hit;
  // ir_q is read before its own update, so a coincident uir/udr uses the old channel.
  assign accept  = udr_rise && CH_EN[ir_q] && !blocked;
  assign ovr_evt = udr_rise && !accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync <= '0;
      udr_sync <= '0;
      uir_dly  <= 1'b0;
      udr_dly  <= 1'b0;
      ir_q     <= '0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_dly  <= uir_sync[SYNC_STAGES-1];
      udr_dly  <= udr_sync[SYNC_STAGES-1];
      if (uir_rise) begin
        ir_q <= ir_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      cmd_pending    <= 1'b0;
    end else if (accept) begin
      jdo            <= sr;
      take_action    <= sr[ACT_BIT] ? ch_onehot : '0;
      take_no_action <= sr[ACT_BIT] ? '0 : ch_onehot;
      cmd_pending    <= (ACK_MODE != 0);
    end else if ((ACK_MODE == 0) || ack_hit) begin
      take_action    <= '0;
      take_no_action <= '0;
      cmd_pending    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else if (overrun_clr) begin
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else if (ovr_evt) begin
      overrun <= 1'b1;
      if (overrun_cnt != {CNT_W{1'b1}}) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbg_cmd_sysclk_decoder.sv
// tb/tb_dbg_cmd_sysclk_decoder.sv - bench for dbg_cmd_sysclk_decoder (three parameter sets, shared stimulus)
module tb_dbg_cmd_sysclk_decoder;

  localparam int SS = 2;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs_uir = 1'b0;
  logic        vs_udr = 1'b0;
  logic [1:0]  ir_in = 2'b00;
  logic [37:0] sr = '0;
  logic [3:0]  action_ack = '0;
  logic        overrun_clr = 1'b0;

  logic [37:0] jdo_o  [NI];
  logic [3:0]  ta_o   [NI];
  logic [3:0]  tna_o  [NI];
  logic        pend_o [NI];
  logic        ovr_o  [NI];
  logic [7:0]  cnt_o  [NI];

  always #5 clk = ~clk;

  // instance 0: defaults; instance 1: ACK_MODE=1; instance 2: CH_EN=4'b1101
  dbg_cmd_sysclk_decoder u_def (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .action_ack(action_ack), .overrun_clr(overrun_clr), .jdo(jdo_o[0]), .take_action(ta_o[0]),
    .take_no_action(tna_o[0]), .cmd_pending(pend_o[0]), .overrun(ovr_o[0]), .overrun_cnt(cnt_o[0]));

  dbg_cmd_sysclk_decoder #(.ACK_MODE(1)) u_ack (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .action_ack(action_ack), .overrun_clr(overrun_clr), .jdo(jdo_o[1]), .take_action(ta_o[1]),
    .take_no_action(tna_o[1]), .cmd_pending(pend_o[1]), .overrun(ovr_o[1]), .overrun_cnt(cnt_o[1]));

  dbg_cmd_sysclk_decoder #(.CH_EN(4'b1101)) u_msk (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .action_ack(action_ack), .overrun_clr(overrun_clr), .jdo(jdo_o[2]), .take_action(ta_o[2]),
    .take_no_action(tna_o[2]), .cmd_pending(pend_o[2]), .overrun(ovr_o[2]), .overrun_cnt(cnt_o[2]));

  // reference model: per-instance command state
  int          p_ack [NI] = '{0, 1, 0};
  logic [3:0]  p_en  [NI] = '{4'hF, 4'hF, 4'hD};
  logic [37:0] m_jdo [NI];
  logic [3:0]  m_ta  [NI];
  logic [3:0]  m_tna [NI];
  bit          m_pend[NI];
  int          m_pch [NI];
  bit          m_ovr [NI];
  int          m_cnt [NI];
  int          m_ir;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s.i%0d.jdo", tag, i), 64'(jdo_o[i]), 64'(m_jdo[i]));
      check($sformatf("%s.i%0d.ta", tag, i), 64'(ta_o[i]), 64'(m_ta[i]));
      check($sformatf("%s.i%0d.tna", tag, i), 64'(tna_o[i]), 64'(m_tna[i]));
      check($sformatf("%s.i%0d.pend", tag, i), 64'(pend_o[i]), 64'(m_pend[i]));
      check($sformatf("%s.i%0d.ovr", tag, i), 64'(ovr_o[i]), 64'(m_ovr[i]));
      check($sformatf("%s.i%0d.cnt", tag, i), 64'(cnt_o[i]), 64'(m_cnt[i]));
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      m_jdo[i] = '0; m_ta[i] = '0; m_tna[i] = '0;
      m_pend[i] = 0; m_pch[i] = 0; m_ovr[i] = 0; m_cnt[i] = 0;
    end
    m_ir = 0;
  endfunction

  function automatic void model_ack(input logic [3:0] ack);
    for (int i = 0; i < NI; i++) begin
      if (m_pend[i] && ack[m_pch[i]]) begin
        m_pend[i] = 0; m_ta[i] = '0; m_tna[i] = '0;
      end
    end
  endfunction

  function automatic void model_udr(input int ch, input logic [37:0] s, input logic [3:0] ack, input bit clr);
    model_ack(ack);
    for (int i = 0; i < NI; i++) begin
      if (p_en[i][ch] && !m_pend[i]) begin
        m_jdo[i] = s; m_ta[i] = '0; m_tna[i] = '0;
        if (s[34]) m_ta[i][ch] = 1'b1;
        else       m_tna[i][ch] = 1'b1;
        if (p_ack[i] != 0) begin
          m_pend[i] = 1; m_pch[i] = ch;
        end
      end else begin
        m_ovr[i] = 1;
        if (m_cnt[i] < 255) m_cnt[i]++;
      end
      if (clr) begin
        m_ovr[i] = 0; m_cnt[i] = 0;
      end
    end
  endfunction

  function automatic void model_tick();
    for (int i = 0; i < NI; i++) begin
      if (p_ack[i] == 0) begin
        m_ta[i] = '0; m_tna[i] = '0;
      end
    end
  endfunction

  task automatic send_uir(input logic [1:0] v);
    @(negedge clk);
    ir_in = v; vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    vs_uir = 1'b0;
    repeat (3) @(negedge clk);
    m_ir = int'(v);
  endtask

  // Entered at a negedge with vs_udr already high; the next posedge is the first sampling edge.
  task automatic accept_phase(input logic [3:0] ack_v, input bit clr_v, input bit do_check);
    repeat (SS) @(negedge clk);
    if (do_check) check_all("pre");
    action_ack = ack_v; overrun_clr = clr_v;
    @(negedge clk);
    model_udr(m_ir, sr, ack_v, clr_v);
    if (do_check) check_all("acc");
    action_ack = '0; overrun_clr = 1'b0;
    @(negedge clk);
    model_tick();
    if (do_check) check_all("post");
    vs_udr = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_udr(input logic [37:0] s, input logic [3:0] ack_v, input bit clr_v, input bit do_check);
    @(negedge clk);
    sr = s; vs_udr = 1'b1;
    accept_phase(ack_v, clr_v, do_check);
  endtask

  task automatic send_ack(input logic [3:0] v);
    @(negedge clk);
    action_ack = v;
    @(negedge clk);
    model_ack(v);
    check_all("ack");
    action_ack = '0;
  endtask

  task automatic send_clr();
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      m_ovr[i] = 0; m_cnt[i] = 0;
    end
    check_all("clr");
    overrun_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // action on ch1, then no-action on ch3
    send_uir(2'b01);
    send_udr(38'h04_0000_1234, 4'b0000, 1'b0, 1'b1);
    send_uir(2'b11);
    send_udr(38'h00_0000_5678, 4'b0000, 1'b0, 1'b1);
    send_ack(4'b0010);

    // ch0: held command, blocked second command, ack, then ack coinciding with a new command
    send_uir(2'b00);
    send_udr(38'h04_1111_0000, 4'b0000, 1'b0, 1'b1);
    send_udr(38'h00_2222_0000, 4'b0000, 1'b0, 1'b1);
    send_ack(4'b0100);
    send_ack(4'b0001);
    send_udr(38'h04_3333_0000, 4'b0000, 1'b0, 1'b1);
    send_udr(38'h00_4444_0000, 4'b0001, 1'b0, 1'b1);

    // repeated commands on masked ch1 saturate the counters
    send_uir(2'b01);
    for (int n = 0; n < 300; n++) begin
      send_udr({6'($urandom), 32'($urandom)}, 4'b0000, 1'b0, 1'b0);
    end
    check_all("sat");
    send_clr();
    // clear on the same edge as an overrun event
    send_udr(38'h04_5555_0000, 4'b0000, 1'b1, 1'b1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) send_uir(2'($urandom));
      send_udr({6'($urandom), 32'($urandom)}, ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000,
               ($urandom_range(0, 7) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) send_ack(4'($urandom));
    end

    // reset while a command is held, with vs_udr high through release
    send_uir(2'b10);
    send_udr(38'h04_6666_0000, 4'b0000, 1'b0, 1'b1);
    check($sformatf("pend_before_reset"), 64'(pend_o[1]), 64'd1);
    @(negedge clk);
    sr = 38'h04_7777_0000; vs_udr = 1'b1;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("arst");
    @(negedge clk);
    reset = 1'b0;
    accept_phase(4'b0000, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_sysclk_decoder.md
Name: dbg_cmd_sysclk_decoder

Overview:
System-clock side of the JTAG debug slave, generalised successor to the fixed 2-bit-IR / 38-bit-SR decoder. It synchronises the virtual-JTAG update-IR and update-DR strobes into clk, captures the instruction and shift-register snapshot, and decodes them into per-channel take_action / take_no_action strobes. Channel count, widths, synchroniser depth and enable mask are parametrised. An optional acknowledge mode holds a command until the consuming debug unit accepts it, with overrun detection and counting.

Parameters:
SR_W, 38, width of sr capture and jdo
IR_W, 2, instruction width; NUM_CH = 2**IR_W (derived localparam)
ACT_BIT, 34, sr bit selecting take_action (1) vs take_no_action (0); must be < SR_W
SYNC_STAGES, 2, synchroniser flops per strobe; legal range 2..4
CH_EN, all ones (NUM_CH bits), per-channel enable mask
ACK_MODE, 0, 0 = one-cycle strobes; 1 = level held until action_ack
CNT_W, 8, overrun counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
vs_uir  in  1  update-IR level from TCK domain (async)
vs_udr  in  1  update-DR level from TCK domain (async)
ir_in  in  IR_W  instruction from TCK domain; stable around vs_uir
sr  in  SR_W  shift-register contents; stable around vs_udr
action_ack  in  NUM_CH  per-channel accept (ACK_MODE=1 only; ignored otherwise)
overrun_clr  in  1  clears overrun and overrun_cnt
jdo  out  SR_W  captured sr snapshot
take_action  out  NUM_CH  per-channel action strobe/level
take_no_action  out  NUM_CH  per-channel no-action strobe/level
cmd_pending  out  1  ACK_MODE=1: a command awaits ack
overrun  out  1  sticky: command arrived while pending, or on a disabled channel
overrun_cnt  out  CNT_W  saturating count of overrun events

Behaviour:
- Reset (async assert, sync release): all synchroniser and edge flops, ir_q, jdo, take_action, take_no_action, cmd_pending, overrun and overrun_cnt are 0.
- Each strobe passes through a SYNC_STAGES flop chain plus one delay flop.
- rise = last stage & ~delay.
- uir_rise: ir_q <= ir_in.
- udr_rise: ch = ir_q value held before this edge. If uir_rise and udr_rise coincide, udr uses the old ir_q and ir_q updates on the same edge.
- Latency: counting the first clk edge that samples vs_udr high as edge 1, jdo and the strobes update on edge SYNC_STAGES+1 (edge 3 by default).
- Accept (udr_rise, CH_EN[ch]=1, not blocked):
  - jdo <= sr.
  - If sr[ACT_BIT]=1, take_action[ch] <= 1; else take_no_action[ch] <= 1.
  - At most one bit across both vectors is ever high.
- ACK_MODE=0:
  - Strobes are high for exactly one cycle.
  - Back-to-back udr rises, one cycle apart minimum after synchronisation, each produce a pulse. Never blocked.
- ACK_MODE=1:
  - The asserted bit and cmd_pending stay high until action_ack[ch]=1 on a clock edge. Acks on other channels are ignored.
  - While pending, a udr_rise is blocked: jdo and the strobes are unchanged, overrun <= 1, and overrun_cnt increments.
  - Ack and udr_rise on the same edge: pending clears and the new command is accepted on that edge. This is not an overrun.
- Disabled channel (CH_EN[ch]=0): no strobe, jdo unchanged, overrun <= 1, overrun_cnt increments.
- overrun_cnt saturates at 2**CNT_W-1.
- overrun_clr has priority over a same-edge increment: the result is 0 and overrun is 0.
- Reset mid-pending discards the command. The synchroniser restarts, so a vs_udr still high after release produces a rise once synchronised. This is intentional and matches TCK-side replay.
- vs_udr pulses shorter than 1 clk period may be missed; the TCK side guarantees ≥ 2 clk periods.

Test Plan:
- Defaults: uir with ir_in=2'b01, then udr with sr=38'h04_0000_1234 (bit34=1) -> edge 3 after udr sampled: jdo=38'h04_0000_1234, take_action=4'b0010 for 1 cycle, take_no_action=0.
- Same with sr bit34=0, ir_in=2'b11 -> take_no_action=4'b1000 pulse; take_action stays 0.
- ACK_MODE=1: command on ch0, no ack, second udr with new sr -> take_action[0] held, jdo unchanged, overrun=1, overrun_cnt=1. Then action_ack=4'b0001 -> pending and strobe drop next edge.
- ACK_MODE=1: action_ack[0] and the next udr_rise on the same edge -> new jdo captured, cmd_pending stays 1, overrun_cnt unchanged.
- CH_EN=4'b1101, command on ch1 -> no strobe, overrun=1. Repeat 300 times with CNT_W=8 -> overrun_cnt=255. Then overrun_clr -> 0.
- Assert reset while cmd_pending=1 -> all outputs 0 immediately (async). After release, with vs_udr held high, one strobe appears SYNC_STAGES+1 edges later.
